// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared latency defaults and stall-cause encodings for the hazard scoreboard.
package hazard_scoreboard_unit_pkg;

   localparam int DEF_LOAD_LAT = 1;
   localparam int DEF_MUL_LAT  = 5;

   localparam logic [1:0] STALL_CAUSE_NONE = 2'b00;
   localparam logic [1:0] STALL_CAUSE_RAW  = 2'b01;
   localparam logic [1:0] STALL_CAUSE_WAW  = 2'b10;
   localparam logic [1:0] STALL_CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/hazard_scoreboard_unit_entry.sv
// One scoreboard slot: down-counter of cycles until an in-flight result is usable.
module hazard_scoreboard_unit_entry #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             nz
);

   assign nz = |cnt;

   // A new issue to this register replaces whatever countdown was in flight.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && nz)
         cnt <= cnt - CNT_W'(1);
   end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// RAW/WAW stall generation for the ID stage from a per-register countdown scoreboard.
module hazard_scoreboard_unit
   import hazard_scoreboard_unit_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int LOAD_LAT    = DEF_LOAD_LAT,
   parameter int MUL_LAT     = DEF_MUL_LAT,
   parameter int CNT_W       = 3,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   id_valid_in,
   input  logic [REG_ADDR_W-1:0]  id_reg_a_addr_in,
   input  logic                   id_reg_a_used_in,
   input  logic [REG_ADDR_W-1:0]  id_reg_b_addr_in,
   input  logic                   id_reg_b_used_in,
   input  logic [REG_ADDR_W-1:0]  id_reg_dest_addr_in,
   input  logic                   id_reg_dest_wr_in,
   input  logic                   id_is_load_in,
   input  logic                   id_is_mul_in,
   input  logic                   pipe_freeze_in,
   input  logic                   flush_in,
   output logic                   stall_out,
   output logic [1:0]             stall_cause_out,
   output logic                   busy_out,
   output logic [STALL_CNT_W-1:0] stall_cycles_out
);

   logic [CNT_W-1:0]    cnt [NUM_REGS];
   logic [NUM_REGS-1:0] nz;
   logic [CNT_W-1:0]    new_lat;
   logic                raw, waw, issue, sb_write;

   assign cnt[0] = '0;
   assign nz[0]  = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      hazard_scoreboard_unit_entry #(.CNT_W(CNT_W)) u_entry (
         .clk      (clk),
         .reset    (reset),
         .load     (sb_write && (id_reg_dest_addr_in == REG_ADDR_W'(r))),
         .load_val (new_lat),
         .dec      (!pipe_freeze_in),
         .cnt      (cnt[r]),
         .nz       (nz[r])
      );
   end

   assign new_lat = id_is_mul_in  ? CNT_W'(MUL_LAT)  :
                    id_is_load_in ? CNT_W'(LOAD_LAT) : '0;

   assign raw = id_valid_in &&
                ((id_reg_a_used_in && (id_reg_a_addr_in != '0) && (cnt[id_reg_a_addr_in] != '0)) ||
                 (id_reg_b_used_in && (id_reg_b_addr_in != '0) && (cnt[id_reg_b_addr_in] != '0)));

   // A younger write may not land before an older one to the same register.
   assign waw = id_valid_in && id_reg_dest_wr_in && (id_reg_dest_addr_in != '0) &&
                (cnt[id_reg_dest_addr_in] > new_lat);

   assign stall_out = (raw || waw) && !flush_in;
   assign issue     = id_valid_in && !stall_out && !flush_in && !pipe_freeze_in;
   assign sb_write  = issue && id_reg_dest_wr_in && (id_reg_dest_addr_in != '0) && (new_lat != '0);
   assign busy_out  = |nz;

   always_comb begin
      stall_cause_out = STALL_CAUSE_NONE;
      if (!flush_in) begin
         if (raw && waw)
            stall_cause_out = STALL_CAUSE_BOTH;
         else if (raw)
            stall_cause_out = STALL_CAUSE_RAW;
         else if (waw)
            stall_cause_out = STALL_CAUSE_WAW;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles_out <= '0;
      else if (stall_out && !pipe_freeze_in && !(&stall_cycles_out))
         stall_cycles_out <= stall_cycles_out + STALL_CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed and randomized checks of hazard_scoreboard_unit against a remaining-latency model.
module tb_hazard_scoreboard_unit;

   localparam int LOAD_LAT  = 1;
   localparam int MUL_LAT   = 5;
   localparam int STATS_MAX = 65535;

   logic        clk;
   logic        reset;
   logic        id_valid_in;
   logic [4:0]  id_reg_a_addr_in;
   logic        id_reg_a_used_in;
   logic [4:0]  id_reg_b_addr_in;
   logic        id_reg_b_used_in;
   logic [4:0]  id_reg_dest_addr_in;
   logic        id_reg_dest_wr_in;
   logic        id_is_load_in;
   logic        id_is_mul_in;
   logic        pipe_freeze_in;
   logic        flush_in;
   logic        stall_out;
   logic [1:0]  stall_cause_out;
   logic        busy_out;
   logic [15:0] stall_cycles_out;

   int n_checks = 0;
   int n_fail   = 0;
   int m_cnt [32];
   int m_stats = 0;

   hazard_scoreboard_unit dut (
      .clk                 (clk),
      .reset               (reset),
      .id_valid_in         (id_valid_in),
      .id_reg_a_addr_in    (id_reg_a_addr_in),
      .id_reg_a_used_in    (id_reg_a_used_in),
      .id_reg_b_addr_in    (id_reg_b_addr_in),
      .id_reg_b_used_in    (id_reg_b_used_in),
      .id_reg_dest_addr_in (id_reg_dest_addr_in),
      .id_reg_dest_wr_in   (id_reg_dest_wr_in),
      .id_is_load_in       (id_is_load_in),
      .id_is_mul_in        (id_is_mul_in),
      .pipe_freeze_in      (pipe_freeze_in),
      .flush_in            (flush_in),
      .stall_out           (stall_out),
      .stall_cause_out     (stall_cause_out),
      .busy_out            (busy_out),
      .stall_cycles_out    (stall_cycles_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: m_cnt[r] = cycles until register r's pending result is usable.
   function automatic int m_new_lat();
      if (id_is_mul_in) return MUL_LAT;
      if (id_is_load_in) return LOAD_LAT;
      return 0;
   endfunction

   function automatic bit m_raw();
      bit a_hit, b_hit;
      a_hit = id_reg_a_used_in && id_reg_a_addr_in != 0 && m_cnt[id_reg_a_addr_in] != 0;
      b_hit = id_reg_b_used_in && id_reg_b_addr_in != 0 && m_cnt[id_reg_b_addr_in] != 0;
      return id_valid_in && (a_hit || b_hit);
   endfunction

   function automatic bit m_waw();
      return id_valid_in && id_reg_dest_wr_in && id_reg_dest_addr_in != 0 &&
             m_cnt[id_reg_dest_addr_in] > m_new_lat();
   endfunction

   function automatic bit m_stall();
      return (m_raw() || m_waw()) && !flush_in;
   endfunction

   function automatic logic [1:0] m_cause();
      if (flush_in) return 2'b00;
      return {m_waw(), m_raw()};
   endfunction

   function automatic bit m_busy();
      foreach (m_cnt[r]) if (m_cnt[r] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      bit st;
      int lat;
      st  = m_stall();
      lat = m_new_lat();
      if (reset) begin
         foreach (m_cnt[r]) m_cnt[r] = 0;
         m_stats = 0;
      end else if (!pipe_freeze_in) begin
         if (st && m_stats < STATS_MAX) m_stats++;
         foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
         if (id_valid_in && !st && !flush_in && id_reg_dest_wr_in &&
             id_reg_dest_addr_in != 0 && lat != 0)
            m_cnt[id_reg_dest_addr_in] = lat;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input bit v, input int a, input bit au, input int b, input bit bu,
                        input int rd, input bit wr, input bit ld, input bit ml);
      id_valid_in         = v;
      id_reg_a_addr_in    = 5'(a);
      id_reg_a_used_in    = au;
      id_reg_b_addr_in    = 5'(b);
      id_reg_b_used_in    = bu;
      id_reg_dest_addr_in = 5'(rd);
      id_reg_dest_wr_in   = wr;
      id_is_load_in       = ld;
      id_is_mul_in        = ml;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pipe_freeze_in = 1'b0;
      flush_in = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      instr(1, 5, 1, 0, 0, 5, 1, 1, 0);
      tick();
      do_reset();
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b need 0", stall_out); end
      n_checks++;
      if (stall_cause_out !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %0b need 00", stall_cause_out); end
      n_checks++;
      if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b need 0", busy_out); end
      n_checks++;
      if (stall_cycles_out !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d need 0", stall_cycles_out); end
   endtask

   task automatic test_load_use();
      int stalls = 0;
      bit done = 0;
      do_reset();
      instr(1, 0, 0, 0, 0, 5, 1, 1, 0);
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin n_fail++; $display("FAIL lu_lw_stall: got %0b need 0", stall_out); end
      tick();
      instr(1, 5, 1, 1, 1, 6, 1, 0, 0);
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         n_checks++;
         if (stall_out !== m_stall() || stall_cause_out !== m_cause()) begin
            n_fail++;
            $display("FAIL lu_cycle%0d: stall/cause got %0b/%0b need %0b/%0b", i, stall_out, stall_cause_out, m_stall(), m_cause());
         end
         if (m_stall()) begin
            stalls++;
            n_checks++;
            if (stall_cause_out !== 2'b01) begin n_fail++; $display("FAIL lu_cause: got %0b need 01", stall_cause_out); end
         end else done = 1;
         tick();
      end
      n_checks++;
      if (!done || stalls != LOAD_LAT) begin n_fail++; $display("FAIL lu_stalls: got %0d need %0d", stalls, LOAD_LAT); end
   endtask

   task automatic test_mul_chain();
      int stalls = 0;
      bit done = 0;
      do_reset();
      instr(1, 0, 0, 0, 0, 7, 1, 0, 1);
      tick();
      instr(1, 7, 1, 7, 1, 8, 1, 0, 0);
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         n_checks++;
         if (stall_out !== m_stall() || stall_cause_out !== m_cause() || busy_out !== m_busy()) begin
            n_fail++;
            $display("FAIL mul_cycle%0d: stall/cause/busy got %0b/%0b/%0b need %0b/%0b/%0b", i,
                     stall_out, stall_cause_out, busy_out, m_stall(), m_cause(), m_busy());
         end
         if (m_stall()) stalls++; else done = 1;
         tick();
      end
      n_checks++;
      if (!done || stalls != MUL_LAT) begin n_fail++; $display("FAIL mul_stalls: got %0d need %0d", stalls, MUL_LAT); end
      n_checks++;
      if (stall_cycles_out !== 16'd5) begin n_fail++; $display("FAIL mul_stats: got %0d need 5", stall_cycles_out); end
   endtask

   task automatic test_waw();
      int waw_cycles = 0;
      bit done = 0;
      do_reset();
      instr(1, 0, 0, 0, 0, 9, 1, 0, 1);
      tick();
      instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      instr(1, 0, 0, 0, 0, 9, 1, 1, 0);
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         n_checks++;
         if (stall_out !== m_stall() || stall_cause_out !== m_cause()) begin
            n_fail++;
            $display("FAIL waw_cycle%0d: stall/cause got %0b/%0b need %0b/%0b", i, stall_out, stall_cause_out, m_stall(), m_cause());
         end
         if (m_stall()) begin
            if (m_cause() == 2'b10) waw_cycles++;
         end else done = 1;
         tick();
      end
      n_checks++;
      if (!done || waw_cycles != 3) begin n_fail++; $display("FAIL waw_cycles: got %0d need 3", waw_cycles); end
      n_checks++;
      if (busy_out !== 1'b1) begin n_fail++; $display("FAIL waw_busy_after_lw: got %0b need 1", busy_out); end
   endtask

   task automatic test_x0_unused();
      do_reset();
      instr(1, 0, 0, 0, 0, 0, 1, 1, 0);
      tick();
      instr(1, 0, 1, 0, 1, 6, 1, 0, 0);
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin n_fail++; $display("FAIL x0_src_stall: got %0b need 0", stall_out); end
      n_checks++;
      if (busy_out !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %0b need 0", busy_out); end
      instr(1, 0, 0, 0, 0, 3, 1, 1, 0);
      tick();
      instr(1, 3, 0, 3, 0, 7, 1, 0, 0);
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin n_fail++; $display("FAIL unused_src_stall: got %0b need 0", stall_out); end
      instr(1, 3, 1, 0, 0, 7, 1, 0, 0);
      #1;
      n_checks++;
      if (stall_out !== 1'b1) begin n_fail++; $display("FAIL used_src_stall: got %0b need 1", stall_out); end
      tick();
   endtask

   task automatic test_freeze();
      int stalls = 0;
      bit done = 0;
      do_reset();
      instr(1, 0, 0, 0, 0, 4, 1, 0, 1);
      tick();
      instr(1, 4, 1, 0, 0, 9, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (stall_out !== 1'b1) begin n_fail++; $display("FAIL frz_pre%0d_stall: got %0b need 1", i, stall_out); end
         tick();
      end
      pipe_freeze_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (stall_out !== 1'b1 || busy_out !== 1'b1 || stall_cycles_out !== 16'd2) begin
            n_fail++;
            $display("FAIL frz_hold%0d: stall/busy/stats got %0b/%0b/%0d need 1/1/2", i, stall_out, busy_out, stall_cycles_out);
         end
         tick();
      end
      pipe_freeze_in = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         n_checks++;
         if (stall_out !== m_stall() || stall_cycles_out !== 16'(m_stats)) begin
            n_fail++;
            $display("FAIL frz_post%0d: stall/stats got %0b/%0d need %0b/%0d", i, stall_out, stall_cycles_out, m_stall(), m_stats);
         end
         if (m_stall()) stalls++; else done = 1;
         tick();
      end
      n_checks++;
      if (!done || stalls != 3) begin n_fail++; $display("FAIL frz_post_stalls: got %0d need 3", stalls); end
      n_checks++;
      if (stall_cycles_out !== 16'd5) begin n_fail++; $display("FAIL frz_stats: got %0d need 5", stall_cycles_out); end
   endtask

   task automatic test_flush_reset();
      do_reset();
      flush_in = 1'b1;
      instr(1, 0, 0, 0, 0, 2, 1, 1, 0);
      tick();
      flush_in = 1'b0;
      instr(1, 2, 1, 2, 1, 3, 1, 0, 0);
      #1;
      n_checks++;
      if (stall_out !== 1'b0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_no_entry: stall/busy got %0b/%0b need 0/0", stall_out, busy_out);
      end
      tick();
      instr(1, 0, 0, 0, 0, 10, 1, 0, 1);
      tick();
      instr(1, 10, 1, 0, 0, 11, 1, 0, 0);
      flush_in = 1'b1;
      #1;
      n_checks++;
      if (stall_out !== 1'b0 || stall_cause_out !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_gates_stall: stall/cause got %0b/%0b need 0/00", stall_out, stall_cause_out);
      end
      flush_in = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy_out !== 1'b0 || stall_cycles_out !== 16'd0 || stall_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_mul: busy/stats/stall got %0b/%0d/%0b need 0/0/0", busy_out, stall_cycles_out, stall_out);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset          = ($urandom_range(0, 99) == 0);
         pipe_freeze_in = ($urandom_range(0, 9) == 0);
         flush_in       = ($urandom_range(0, 9) == 0);
         instr($urandom_range(0, 9) != 0,
               $urandom_range(0, 7), $urandom_range(0, 1) == 1,
               $urandom_range(0, 7), $urandom_range(0, 1) == 1,
               $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         #1;
         n_checks++;
         if (stall_out !== m_stall() || stall_cause_out !== m_cause() ||
             busy_out !== m_busy() || stall_cycles_out !== 16'(m_stats)) begin
            n_fail++;
            if (bad < 10)
               $display("FAIL rand%0d: stall/cause/busy/stats got %0b/%0b/%0b/%0d need %0b/%0b/%0b/%0d", i,
                        stall_out, stall_cause_out, busy_out, stall_cycles_out,
                        m_stall(), m_cause(), m_busy(), m_stats);
            bad++;
         end
         tick();
      end
      reset = 1'b0;
      pipe_freeze_in = 1'b0;
      flush_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      pipe_freeze_in = 1'b0;
      flush_in = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
      foreach (m_cnt[r]) m_cnt[r] = 0;
      @(posedge clk);
      #1;
      tick();
      reset = 1'b0;
      test_reset();
      test_load_use();
      test_mul_chain();
      test_waw();
      test_x0_unused();
      test_freeze();
      test_flush_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
